cmos_pixel_packer: RTL and testbench

CMOS_PIXEL_PACKER -- requirements
Module: cmos_pixel_packer

---
 rtl/cmos_pixel_packer.sv | 216 +++++++++++++++++++++
 tb/tb_cmos_pixel_packer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module      : cmos_pixel_packer
//  Description : Captures a DVP-style CMOS sensor byte stream (VSYNC/HREF/D[7:0])
//                and packs byte pairs into RGB565 words. It discards a number
//                of settling frames after enable, emits a frame-sync pulse per
//                captured frame and flags malformed lines and frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmos_pixel_packer #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        vs_in,
    input  logic        href_in,
    input  logic [7:0]  data_in,
    output logic        wr_en,
    output logic [15:0] wr_data,
    output logic        frame_sync,
    output logic [7:0]  frame_cnt,
    output logic        line_err,
    output logic        frame_err,
    output logic        capturing
);

    // Skip counter only needs to reach SKIP_FRAMES; keep at least one bit.
    localparam int             c_SKW      = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);
    localparam logic [10:0]    c_H_TGT    = 11'(H_ACTIVE);
    localparam logic [9:0]     c_V_TGT    = 10'(V_ACTIVE);
    localparam logic [c_SKW-1:0] c_SKIP_TGT = c_SKW'(SKIP_FRAMES);
    localparam bit             c_NO_SKIP  = (SKIP_FRAMES == 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_SKIP    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t             state_q;
    logic               vs_s1_q, href_s1_q, vs_s2_q, href_s2_q;
    logic [7:0]         data_s1_q;
    logic [c_SKW-1:0]   skip_cnt_q;
    logic               phase_q;
    logic [7:0]         hi_byte_q;
    logic [10:0]        pix_cnt_q;
    logic [9:0]         line_cnt_q;
    logic               pix_vld_q;
    logic [15:0]        pix_data_q;
    logic               wr_en_q;
    logic [15:0]        wr_data_q;
    logic               frame_sync_q;
    logic [7:0]         frame_cnt_q;
    logic               line_err_q;
    logic               frame_err_q;
    logic               capturing_q;

    logic w_vs_fall, w_vs_rise, w_href_fall, w_byte_ok, w_skip_done, w_start_frame;

    // Edges are taken between the first register stage and its delayed copy.
    assign w_vs_fall   = vs_s2_q & ~vs_s1_q;
    assign w_vs_rise   = ~vs_s2_q & vs_s1_q;
    assign w_href_fall = href_s2_q & ~href_s1_q;
    assign w_byte_ok   = href_s1_q & ~vs_s1_q;
    assign w_skip_done = ((skip_cnt_q + c_SKW'(1)) == c_SKIP_TGT);

    // A VS falling edge opens a captured frame when already capturing, or when
    // it is the edge that ends the settling period.
    assign w_start_frame = w_vs_fall &&
                           ((state_q == ST_CAPTURE) ||
                            (enable && (state_q == ST_SYNC) && c_NO_SKIP) ||
                            (enable && (state_q == ST_SKIP) && w_skip_done));

    // Register the raw sensor inputs once, plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_s1_q   <= 1'b0;
            href_s1_q <= 1'b0;
            data_s1_q <= 8'd0;
            vs_s2_q   <= 1'b0;
            href_s2_q <= 1'b0;
        end else begin
            vs_s1_q   <= vs_in;
            href_s1_q <= href_in;
            data_s1_q <= data_in;
            vs_s2_q   <= vs_s1_q;
            href_s2_q <= href_s1_q;
        end
    end

    // Control FSM, byte packing, line/frame bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            skip_cnt_q   <= '0;
            phase_q      <= 1'b0;
            hi_byte_q    <= 8'd0;
            pix_cnt_q    <= 11'd0;
            line_cnt_q   <= 10'd0;
            pix_vld_q    <= 1'b0;
            pix_data_q   <= 16'd0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= 16'd0;
            frame_sync_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            capturing_q  <= 1'b0;
        end else begin
            // Second pipeline stage: a packed pixel becomes a write one cycle later.
            wr_en_q      <= pix_vld_q;
            if (pix_vld_q) begin
                wr_data_q <= pix_data_q;
            end
            pix_vld_q    <= 1'b0;
            frame_sync_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    capturing_q <= 1'b0;
                    phase_q     <= 1'b0;
                    pix_cnt_q   <= 11'd0;
                    if (enable) begin
                        state_q <= ST_SYNC;
                    end
                end

                ST_SYNC: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end else if (w_vs_fall) begin
                        skip_cnt_q <= '0;
                        state_q    <= c_NO_SKIP ? ST_CAPTURE : ST_SKIP;
                    end
                end

                ST_SKIP: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end else if (w_vs_fall) begin
                        skip_cnt_q <= skip_cnt_q + c_SKW'(1);
                        if (w_skip_done) begin
                            state_q <= ST_CAPTURE;
                        end
                    end
                end

                ST_CAPTURE: begin
                    // A coincident VS fall wins; the frame-start block below clears counters.
                    if (!w_vs_fall) begin
                        if (w_href_fall && !vs_s1_q) begin
                            if (line_cnt_q != 10'h3FF) begin
                                line_cnt_q <= line_cnt_q + 10'd1;
                            end
                            if ((pix_cnt_q != c_H_TGT) || phase_q) begin
                                line_err_q <= 1'b1;
                            end
                            phase_q   <= 1'b0;
                            pix_cnt_q <= 11'd0;
                        end else if (w_byte_ok) begin
                            if (!phase_q) begin
                                hi_byte_q <= data_s1_q;
                                phase_q   <= 1'b1;
                            end else begin
                                pix_data_q <= {hi_byte_q, data_s1_q};
                                pix_vld_q  <= 1'b1;
                                phase_q    <= 1'b0;
                                if (pix_cnt_q != 11'h7FF) begin
                                    pix_cnt_q <= pix_cnt_q + 11'd1;
                                end
                            end
                        end

                        if (w_vs_rise) begin
                            if (line_cnt_q != c_V_TGT) begin
                                frame_err_q <= 1'b1;
                            end
                            // A disable during capture takes effect at the frame boundary.
                            if (!enable) begin
                                state_q     <= ST_IDLE;
                                capturing_q <= 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (w_start_frame) begin
                capturing_q  <= 1'b1;
                frame_sync_q <= 1'b1;
                frame_cnt_q  <= frame_cnt_q + 8'd1;
                line_cnt_q   <= 10'd0;
                pix_cnt_q    <= 11'd0;
                phase_q      <= 1'b0;
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign frame_sync = frame_sync_q;
    assign frame_cnt  = frame_cnt_q;
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;
    assign capturing  = capturing_q;

endmodule
`default_nettype wire

// File: tb/tb_cmos_pixel_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmos_pixel_packer
//  Description : Self-checking bench for cmos_pixel_packer with a small frame
//                geometry (4 pixels x 2 lines, one settling frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmos_pixel_packer;

    localparam int H_ACTIVE    = 4;
    localparam int V_ACTIVE    = 2;
    localparam int SKIP_FRAMES = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        vs_in;
    logic        href_in;
    logic [7:0]  data_in;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        frame_sync;
    logic [7:0]  frame_cnt;
    logic        line_err;
    logic        frame_err;
    logic        capturing;

    always #5 clk = ~clk;

    cmos_pixel_packer #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .SKIP_FRAMES (SKIP_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .vs_in      (vs_in),
        .href_in    (href_in),
        .data_in    (data_in),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .frame_sync (frame_sync),
        .frame_cnt  (frame_cnt),
        .line_err   (line_err),
        .frame_err  (frame_err),
        .capturing  (capturing)
    );

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl[8];
    logic [15:0] exp_ramp[4];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int fs_count = 0;
    int fs_base = 0;

    logic [15:0] wq_data[$];
    int          wq_cyc[$];
    int          sb_cyc[$];
    logic [15:0] exp_q[$];
    logic [7:0]  stream[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write with the edge that produced it, and count frame syncs.
    always @(negedge clk) begin
        if (wr_en) begin
            wq_data.push_back(wr_data);
            wq_cyc.push_back(cyc);
        end
        if (frame_sync) fs_count = fs_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
        chk({tag, "_wr_data"},    32'(wr_data),    32'd0);
        chk({tag, "_frame_sync"}, 32'(frame_sync), 32'd0);
        chk({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
        chk({tag, "_line_err"},   32'(line_err),   32'd0);
        chk({tag, "_frame_err"},  32'(frame_err),  32'd0);
        chk({tag, "_capturing"},  32'(capturing),  32'd0);
    endtask

    // Queue lines of bytes 0x01.. and, when capture is expected, their pixels.
    task automatic fill_ramp(input int nlines, input int first_len, input bit cap);
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == 0) ? first_len : 8;
            for (int b = 0; b < len; b++) stream.push_back(8'(b + 1));
            if (cap) for (int k = 0; k < len / 2; k++) exp_q.push_back(exp_ramp[k]);
        end
    endtask

    task automatic send_line(input int n, input bit cap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vs_in   = 1'b0;
            href_in = 1'b1;
            data_in = stream.pop_front();
            if (cap && (i % 2 == 1)) sb_cyc.push_back(cyc + 1);
        end
        repeat (3) begin
            @(negedge clk);
            href_in = 1'b0;
            data_in = 8'd0;
        end
    endtask

    // VS low (frame start), lines, then VS high (frame end).
    task automatic run_frame(input int nlines, input int first_len, input bit cap, input bit drop_en);
        repeat (2) begin
            @(negedge clk);
            vs_in = 1'b0; href_in = 1'b0; data_in = 8'd0;
        end
        for (int l = 0; l < nlines; l++) begin
            send_line((l == 0) ? first_len : 8, cap);
            if (drop_en && l == 0) enable = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            vs_in = 1'b1; href_in = 1'b0; data_in = 8'd0;
        end
    endtask

    task automatic check_writes(input string name);
        int n;
        chk({name, "_count"}, 32'(wq_data.size()), 32'(exp_q.size()));
        n = wq_data.size();
        if (exp_q.size() < n)  n = exp_q.size();
        if (sb_cyc.size() < n) n = sb_cyc.size();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_data%0d", name, k), 32'(wq_data[k]), 32'(exp_q[k]));
            chk($sformatf("%s_lat%0d", name, k), 32'(wq_cyc[k] - sb_cyc[k]), 32'd2);
        end
        wq_data.delete();
        wq_cyc.delete();
        sb_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        tbl[0] = '{8'hAA, 8'hBB, 16'hAABB};
        tbl[1] = '{8'h00, 8'hFF, 16'h00FF};
        tbl[2] = '{8'hFF, 8'h00, 16'hFF00};
        tbl[3] = '{8'h12, 8'h34, 16'h1234};
        tbl[4] = '{8'h80, 8'h01, 16'h8001};
        tbl[5] = '{8'h5A, 8'hA5, 16'h5AA5};
        tbl[6] = '{8'hFE, 8'hDC, 16'hFEDC};
        tbl[7] = '{8'h01, 8'h10, 16'h0110};
        exp_ramp[0] = 16'h0102;
        exp_ramp[1] = 16'h0304;
        exp_ramp[2] = 16'h0506;
        exp_ramp[3] = 16'h0708;

        rst = 1'b1; enable = 1'b0; vs_in = 1'b1; href_in = 1'b0; data_in = 8'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b0;
        enable = 1'b1;

        // Settling frame: nothing written.
        fs_base = fs_count;
        fill_ramp(2, 8, 1'b0);
        run_frame(2, 8, 1'b0, 1'b0);
        check_writes("skip_frame");
        chk("skip_fsync", 32'(fs_count - fs_base), 32'd0);
        chk("skip_capturing", 32'(capturing), 32'd0);

        // Two captured frames of ramp data.
        fill_ramp(2, 8, 1'b1); run_frame(2, 8, 1'b1, 1'b0);
        fill_ramp(2, 8, 1'b1); run_frame(2, 8, 1'b1, 1'b0);
        check_writes("two_frames");
        chk("two_fsync", 32'(fs_count - fs_base), 32'd2);
        chk("two_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("two_line_err", 32'(line_err), 32'd0);
        chk("two_frame_err", 32'(frame_err), 32'd0);
        chk("two_capturing", 32'(capturing), 32'd1);

        // Table frame: per-pixel data and two-cycle latency.
        for (int k = 0; k < 8; k++) begin
            stream.push_back(tbl[k].hi);
            stream.push_back(tbl[k].lo);
            exp_q.push_back(tbl[k].exp);
        end
        run_frame(2, 8, 1'b1, 1'b0);
        check_writes("table");
        chk("table_frame_cnt", 32'(frame_cnt), 32'd3);

        // Frame with one extra line.
        fill_ramp(3, 8, 1'b1); run_frame(3, 8, 1'b1, 1'b0);
        check_writes("three_lines");
        chk("three_frame_err", 32'(frame_err), 32'd1);
        chk("three_line_err", 32'(line_err), 32'd0);

        // Odd-length line: trailing byte dropped, sticky line error.
        fill_ramp(2, 7, 1'b1); run_frame(2, 7, 1'b1, 1'b0);
        check_writes("short_line");
        chk("short_line_err", 32'(line_err), 32'd1);
        fill_ramp(2, 8, 1'b1); run_frame(2, 8, 1'b1, 1'b0);
        check_writes("after_short");
        chk("line_err_sticky", 32'(line_err), 32'd1);

        // Enable drops after the first line: frame completes, then stop.
        fs_base = fs_count;
        fill_ramp(2, 8, 1'b1); run_frame(2, 8, 1'b1, 1'b1);
        check_writes("en_drop");
        chk("en_drop_capturing", 32'(capturing), 32'd0);
        chk("en_drop_fsync", 32'(fs_count - fs_base), 32'd1);
        fill_ramp(2, 8, 1'b0); run_frame(2, 8, 1'b0, 1'b0);
        check_writes("disabled");
        chk("disabled_fsync", 32'(fs_count - fs_base), 32'd1);
        chk("disabled_frame_cnt", 32'(frame_cnt), 32'd7);

        // Re-enable, skip one frame, then reset in the middle of line 2.
        enable = 1'b1;
        fill_ramp(2, 8, 1'b0); run_frame(2, 8, 1'b0, 1'b0);
        check_writes("resync_skip");
        repeat (2) begin
            @(negedge clk);
            vs_in = 1'b0; href_in = 1'b0; data_in = 8'd0;
        end
        fill_ramp(1, 8, 1'b1);
        send_line(8, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            href_in = 1'b1;
            data_in = 8'(i * 8'h11);
        end
        @(negedge clk);
        href_in = 1'b1; data_in = 8'h44; rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        href_in = 1'b1; data_in = 8'h55;
        for (int i = 6; i <= 8; i++) begin
            @(negedge clk);
            href_in = 1'b1;
            data_in = 8'(i * 8'h11);
        end
        repeat (3) begin
            @(negedge clk);
            href_in = 1'b0; data_in = 8'd0;
        end
        repeat (3) begin
            @(negedge clk);
            vs_in = 1'b1;
        end
        check_writes("midrst");

        // After reset one frame is discarded, then capture resumes.
        fs_base = fs_count;
        fill_ramp(2, 8, 1'b0); run_frame(2, 8, 1'b0, 1'b0);
        check_writes("post_rst_skip");
        chk("post_rst_skip_fsync", 32'(fs_count - fs_base), 32'd0);
        fill_ramp(2, 8, 1'b1); run_frame(2, 8, 1'b1, 1'b0);
        check_writes("post_rst_cap");
        chk("post_rst_fsync", 32'(fs_count - fs_base), 32'd1);
        chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("post_rst_line_err", 32'(line_err), 32'd0);
        chk("post_rst_frame_err", 32'(frame_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
